// File: rtl/timer_irq_source_pkg.sv
// rtl/timer_irq_source_pkg.sv - register map, CTRL fields, MODE and FSM encodings for timer_irq_source
//
// Purpose: shared constants for the timer interrupt source.
// Contents:
//   ADDR_*   word offsets of the memory-mapped registers
//   CTRL_*   bit positions inside CTRL
//   MODE_*   CTRL.MODE encodings (2 and 3 behave as one-shot)
//   ST_*     FSM state encodings
//   ctrl_pack  builds the 32-bit CTRL read value from its fields
package timer_irq_source_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // CTRL[31:4] always read as zero.
    function automatic logic [31:0] ctrl_pack(input logic en, input logic [1:0] mode, input logic im);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN]               = en;
        v[CTRL_MODE_LO +: 2]     = mode;
        v[CTRL_IM]               = im;
        return v;
    endfunction

endpackage

// File: rtl/timer_irq_source.sv
// rtl/timer_irq_source.sv - memory-mapped programmable down-counter raising a CP0 interrupt
//
// Purpose: software-programmed timer; on expiry it raises irq (level in one-shot,
//          one-cycle pulse per period in auto-reload). Writing CTRL or PRESET acks.
// Ports:
//   clk          in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high
//   addr         in   2      word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//   writeEnable  in   1      one-cycle write strobe
//   writeData    in   32     write data
//   readData     out  32     combinational read of the register selected by addr
//   irq          out  1      level interrupt request towards CP0 externalInterrupt
module timer_irq_source
    import timer_irq_source_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        writeEnable,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        irq
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             ctrl_en;
    logic [1:0]       ctrl_mode;
    logic             ctrl_im;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             irq_hold;

    logic ctrl_wr;
    logic preset_wr;
    logic reload_mode;

    assign ctrl_wr     = writeEnable && (addr == ADDR_CTRL);
    assign preset_wr   = writeEnable && (addr == ADDR_PRESET);
    assign reload_mode = (ctrl_mode == MODE_RELOAD);

    // Register writes come first in the block so that the FSM assignments
    // below take priority: INT clearing EN beats a coincident CTRL write, and
    // INT setting irq_hold beats a coincident ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            state     <= ST_IDLE;
            irq_hold  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en   <= writeData[CTRL_EN];
                ctrl_mode <= writeData[CTRL_MODE_LO +: 2];
                ctrl_im   <= writeData[CTRL_IM];
            end
            if (preset_wr) begin
                preset <= writeData[WIDTH-1:0];
            end
            if (ctrl_wr || preset_wr) begin
                irq_hold <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    // A zero preset has nothing to count down, so expiry is
                    // immediate and the period stays PRESET+2 cycles.
                    state <= (preset == '0) ? ST_INT : ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count > ONE) begin
                        count <= count - ONE;
                    end else begin
                        count <= '0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (reload_mode) begin
                        state <= ST_LOAD;
                    end else begin
                        irq_hold <= 1'b1;
                        ctrl_en  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign irq = ctrl_im && (irq_hold || ((state == ST_INT) && reload_mode));

    always_comb begin
        readData = '0;
        case (addr)
            ADDR_CTRL:   readData = ctrl_pack(ctrl_en, ctrl_mode, ctrl_im);
            ADDR_PRESET: readData = 32'(preset);
            ADDR_COUNT:  readData = 32'(count);
            default:     readData = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_irq_source.sv
// tb/tb_timer_irq_source.sv - self-checking bench for timer_irq_source
module tb_timer_irq_source;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        writeEnable = 1'b0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [1:0] A_CTRL = 2'd0, A_PRESET = 2'd1, A_COUNT = 2'd2, A_RSVD = 2'd3;

    timer_irq_source #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .readData    (readData),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, readData, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        chk(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    // One write, committed at the next edge; returns just after that edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr        = a;
        writeData   = d;
        writeEnable = 1'b1;
        tick();
        writeEnable = 1'b0;
        writeData   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Reference timing, counted in edges k after the edge committing EN=1.
    // Expiry lands at edge P+2; one-shot irq rises one edge later, auto-reload
    // pulses in the cycle after each expiry with a period of P+2.
    function automatic logic m_irq(input int p, input bit reload, input bit im, input int k);
        if (!im) return 1'b0;
        if (reload) return (k >= p + 2) && (((k - (p + 2)) % (p + 2)) == 0);
        return k >= p + 3;
    endfunction

    function automatic int m_count(input int p, input bit reload, input int k, input int start);
        int j;
        if (k < 2) return start;
        if (k <= p + 2) return p - (k - 2);
        if (!reload) return 0;
        j = ((k - 1) % (p + 2)) + 1;
        return (j == 1) ? 0 : p - (j - 2);
    endfunction

    initial begin
        int p, mode, im, ncyc;
        bit reload;
        logic [31:0] ctrl_exp;

        // 1. reset state
        tick(2);
        reset = 1'b0;
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_preset", A_PRESET, 32'h0);
        rd_chk("rst_count", A_COUNT, 32'h0);
        rd_chk("rst_rsvd", A_RSVD, 32'h0);
        irq_chk("rst_irq", 1'b0);

        // writes to COUNT and reserved are ignored
        wr(A_COUNT, 32'h1234);
        wr(A_RSVD, 32'hFFFF_FFFF);
        rd_chk("ign_count", A_COUNT, 32'h0);
        rd_chk("ign_rsvd", A_RSVD, 32'h0);
        wr(A_CTRL, 32'hFFFF_FFF0);
        rd_chk("ctrl_hibits", A_CTRL, 32'h0);

        // 2. one-shot, PRESET=3
        do_reset();
        wr(A_PRESET, 32'd3);
        rd_chk("t2_preset", A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            tick();
            rd_chk($sformatf("t2_count_e%0d", k), A_COUNT, m_count(3, 1'b0, k, 0));
            irq_chk($sformatf("t2_irq_e%0d", k), m_irq(3, 1'b0, 1'b1, k));
        end
        rd_chk("t2_ctrl_after", A_CTRL, 32'h8);
        wr(A_CTRL, 32'h8);
        irq_chk("t2_ack", 1'b0);
        tick(2);
        irq_chk("t2_ack_stays", 1'b0);

        // 3. auto-reload, PRESET=2: pulses after edges 4, 8, 12
        do_reset();
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 14; k++) begin
            tick();
            irq_chk($sformatf("t3_irq_e%0d", k), (k == 4) || (k == 8) || (k == 12));
        end
        rd_chk("t3_ctrl", A_CTRL, 32'hB);

        // 4. PRESET=0 one-shot: INT at edge 2, irq after edge 3
        do_reset();
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            tick();
            irq_chk($sformatf("t4_irq_e%0d", k), k >= 3);
            rd_chk($sformatf("t4_count_e%0d", k), A_COUNT, 32'h0);
        end

        // 5a. disable mid-count freezes COUNT; re-enable reloads
        do_reset();
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        tick(3);
        rd_chk("t5_count_e3", A_COUNT, 32'd9);
        wr(A_CTRL, 32'h8);             // commits at edge 4, count decrements once more
        rd_chk("t5_count_e4", A_COUNT, 32'd8);
        tick();
        rd_chk("t5_frozen_e5", A_COUNT, 32'd8);
        tick(3);
        rd_chk("t5_frozen_e8", A_COUNT, 32'd8);
        wr(A_CTRL, 32'h9);
        tick();
        rd_chk("t5_load_edge", A_COUNT, 32'd8);
        tick();
        rd_chk("t5_reloaded", A_COUNT, 32'd10);

        // 5b. PRESET write mid-count takes effect at next reload
        do_reset();
        wr(A_PRESET, 32'd4);
        wr(A_CTRL, 32'hB);
        tick();
        wr(A_PRESET, 32'd5);           // edge 2 -> count 4 (write lands at edge 2)
        rd_chk("t5b_count_e2", A_COUNT, 32'd4);
        tick();
        rd_chk("t5b_count_e3", A_COUNT, 32'd3);
        tick(3);
        rd_chk("t5b_count_e6", A_COUNT, 32'd0);
        irq_chk("t5b_irq_e6", 1'b1);
        tick(2);
        rd_chk("t5b_count_e8", A_COUNT, 32'd5);
        tick();
        rd_chk("t5b_count_e9", A_COUNT, 32'd4);

        // 6a. IM=0 expiry, then IM=1 via CTRL write acks the held request
        do_reset();
        wr(A_PRESET, 32'd1);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            irq_chk($sformatf("t6_masked_e%0d", k), 1'b0);
        end
        wr(A_CTRL, 32'h8);
        irq_chk("t6_unmask_acked", 1'b0);
        tick();
        irq_chk("t6_unmask_stays", 1'b0);

        // 6b. ack write coinciding with the INT-state set: set wins, EN still cleared
        do_reset();
        wr(A_PRESET, 32'd1);
        wr(A_CTRL, 32'h9);
        tick(3);                       // after edge 3: in INT
        wr(A_CTRL, 32'h9);             // commits at edge 4 together with irq_hold set
        irq_chk("t6_coincide_irq", 1'b1);
        rd_chk("t6_coincide_ctrl", A_CTRL, 32'h8);
        tick(2);
        irq_chk("t6_coincide_hold", 1'b1);
        reset = 1'b1;
        tick();
        irq_chk("t6_reset_irq", 1'b0);
        reset = 1'b0;

        // 6c. reset mid-count
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        tick(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_chk("t6_rst_ctrl", A_CTRL, 32'h0);
        rd_chk("t6_rst_preset", A_PRESET, 32'h0);
        rd_chk("t6_rst_count", A_COUNT, 32'h0);
        irq_chk("t6_rst_irq", 1'b0);

        // randomized runs against the reference timing
        for (int t = 0; t < 20; t++) begin
            p      = $urandom_range(0, 6);
            mode   = $urandom_range(0, 3);
            im     = $urandom_range(0, 1);
            reload = (mode == 1);
            ncyc   = 3 * (p + 2) + 3;
            do_reset();
            wr(A_PRESET, 32'(p));
            wr(A_CTRL, 32'(1 + mode * 2 + im * 8));
            for (int k = 1; k <= ncyc; k++) begin
                tick();
                ctrl_exp = 32'(mode * 2 + im * 8);
                if (reload || k < p + 3) ctrl_exp[0] = 1'b1;
                rd_chk($sformatf("rnd%0d_count_e%0d", t, k), A_COUNT, 32'(m_count(p, reload, k, 0)));
                rd_chk($sformatf("rnd%0d_ctrl_e%0d", t, k), A_CTRL, ctrl_exp);
                irq_chk($sformatf("rnd%0d_irq_e%0d", t, k), m_irq(p, reload, im[0], k));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
